// File: rtl/lsu_pkg.sv
// ----------------------------------------------------------------------------
// lsu_pkg
//   Shared types and helpers for the load/store sequencer.
//   - lsu_state_e : sequencer states (IDLE, ACC0, ACC1, RESP)
//   - SZ_B/SZ_H/SZ_W : transfer sizes in bytes
//   - norm_size() : folds unsupported sizes onto a word access
//   - size_mask() : byte-enable mask for a size, before the lane shift
// ----------------------------------------------------------------------------
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2,
        RESP = 2'd3
    } lsu_state_e;

    localparam logic [2:0] SZ_B = 3'd1;
    localparam logic [2:0] SZ_H = 3'd2;
    localparam logic [2:0] SZ_W = 3'd4;

    // Anything other than a byte or halfword is treated as a word access.
    function automatic logic [2:0] norm_size(input logic [2:0] size);
        case (size)
            SZ_B:    return SZ_B;
            SZ_H:    return SZ_H;
            default: return SZ_W;
        endcase
    endfunction

    function automatic logic [3:0] size_mask(input logic [2:0] size);
        case (size)
            SZ_B:    return 4'h1;
            SZ_H:    return 4'h3;
            default: return 4'hF;
        endcase
    endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// ----------------------------------------------------------------------------
// lsu_ctrl_if
//   Word-addressed data-memory port with a req/ack handshake.
//   master (sequencer) : drives req, we, addr, be, wdata; samples ack, rdata
//   slave  (memory)    : the mirror image
//   A phase completes on a clock edge where req and ack are both high.
// ----------------------------------------------------------------------------
interface lsu_ctrl_if;
    logic        req;
    logic        we;
    logic [31:0] addr;   // word aligned, bits [1:0] always zero
    logic [3:0]  be;
    logic [31:0] wdata;  // lane aligned
    logic        ack;
    logic [31:0] rdata;  // valid with ack

    modport master (output req, we, addr, be, wdata, input  ack, rdata);
    modport slave  (input  req, we, addr, be, wdata, output ack, rdata);
endinterface

// File: rtl/lsu_align.sv
// ----------------------------------------------------------------------------
// lsu_align  (purely combinational)
//   Byte-lane alignment for the load/store sequencer.
//   Inputs : off (addr[1:0]), size (normalised 1/2/4), is_unsigned,
//            wdata (right-justified store data), lo/hi (first/second read word)
//   Outputs: lanes     - 8-bit byte mask across the two words touched
//            wdata_lo  - store data for the first word
//            wdata_hi  - store data for the following word
//            load_data - extracted and sign/zero-extended load result
// ----------------------------------------------------------------------------
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [2:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] lo,
    input  logic [31:0] hi,
    output logic [7:0]  lanes,
    output logic [31:0] wdata_lo,
    output logic [31:0] wdata_hi,
    output logic [31:0] load_data
);

    logic [5:0]  shamt;
    logic [63:0] wide_wdata;
    logic [31:0] raw;
    logic        fill;

    assign shamt = {off, 3'b000};

    always_comb begin
        lanes      = {4'b0000, size_mask(size)} << off;

        // Shifting across 64 bits lets a word-crossing store fall naturally
        // into the second word's low lanes.
        wide_wdata = {32'b0, wdata} << shamt;
        wdata_lo   = wide_wdata[31:0];
        wdata_hi   = wide_wdata[63:32];

        raw        = 32'({hi, lo} >> shamt);

        case (size)
            SZ_B: begin
                fill      = ~is_unsigned & raw[7];
                load_data = {{24{fill}}, raw[7:0]};
            end
            SZ_H: begin
                fill      = ~is_unsigned & raw[15];
                load_data = {{16{fill}}, raw[15:0]};
            end
            default: begin
                fill      = 1'b0;
                load_data = raw;
            end
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// ----------------------------------------------------------------------------
// lsu_ctrl
//   MEM-stage load/store sequencer for the RV32I pipeline. Latches a memory
//   request, drives one or two aligned phases on the data-memory port
//   (two when the access crosses a word boundary), and returns the extended
//   load result with a one-cycle done pulse. Each phase aborts with err after
//   MAX_WAIT cycles without ack.
//
//   clk, reset              : core clock, synchronous active-high reset
//   mem_read, mem_write     : request (write wins if both); held while stall
//   xfer_size, is_unsigned  : bytes 1/2/4 (others = 4), zero-extend loads
//   addr, wdata             : byte address, right-justified store data
//   stall                   : freeze pipeline (request cycle and ACC phases)
//   done, rdata, err        : completion pulse, load result, timeout flag
//   dmem                    : data-memory port (master side)
// ----------------------------------------------------------------------------
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 16  // 1..255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  xfer_size,
    input  logic        is_unsigned,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata,
    output logic        err,
    lsu_ctrl_if.master  dmem
);

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    lsu_state_e  state_q, state_d;
    logic        write_q, write_d;
    logic        uns_q, uns_d;
    logic [2:0]  size_q, size_d;
    logic [1:0]  off_q, off_d;
    logic [29:0] waddr_q, waddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] hi_q, hi_d;
    logic [7:0]  wait_q, wait_d;
    logic        timeout_q, timeout_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [7:0]  lanes;
    logic [31:0] wdata_lo, wdata_hi, load_data;
    logic        split;

    lsu_align u_align (
        .off        (off_q),
        .size       (size_q),
        .is_unsigned(uns_q),
        .wdata      (wdata_q),
        .lo         (lo_q),
        .hi         (hi_q),
        .lanes      (lanes),
        .wdata_lo   (wdata_lo),
        .wdata_hi   (wdata_hi),
        .load_data  (load_data)
    );

    assign split = |lanes[7:4];

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case statement can infer a latch.
        state_d     = state_q;
        write_d     = write_q;
        uns_d       = uns_q;
        size_d      = size_q;
        off_d       = off_q;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        lo_d        = lo_q;
        hi_d        = hi_q;
        wait_d      = wait_q;
        timeout_d   = timeout_q;
        rdata_d     = rdata_q;
        err_d       = err_q;

        stall       = 1'b0;
        done        = 1'b0;
        rdata       = rdata_q;
        err         = err_q;
        dmem.req    = 1'b0;
        dmem.we     = 1'b0;
        dmem.addr   = 32'h0;
        dmem.be     = 4'h0;
        dmem.wdata  = 32'h0;

        case (state_q)
            IDLE: begin
                // Stall in the request cycle itself; stray acks are ignored.
                stall = mem_read | mem_write;
                if (mem_read | mem_write) begin
                    write_d   = mem_write;
                    uns_d     = is_unsigned;
                    size_d    = norm_size(xfer_size);
                    off_d     = addr[1:0];
                    waddr_d   = addr[31:2];
                    wdata_d   = wdata;
                    lo_d      = 32'h0;
                    hi_d      = 32'h0;
                    wait_d    = 8'd0;
                    timeout_d = 1'b0;
                    state_d   = ACC0;
                end
            end

            ACC0: begin
                stall      = 1'b1;
                dmem.req   = 1'b1;
                dmem.we    = write_q;
                dmem.addr  = {waddr_q, 2'b00};
                dmem.be    = lanes[3:0];
                dmem.wdata = wdata_lo;
                if (dmem.ack) begin
                    lo_d    = dmem.rdata;
                    wait_d  = 8'd0;
                    state_d = split ? ACC1 : RESP;
                end else if (wait_q == WAIT_LAST) begin
                    // Give up; a split access never reaches its second phase.
                    timeout_d = 1'b1;
                    state_d   = RESP;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end

            ACC1: begin
                stall      = 1'b1;
                dmem.req   = 1'b1;
                dmem.we    = write_q;
                dmem.addr  = {waddr_q + 30'd1, 2'b00};  // wraps at the top
                dmem.be    = lanes[7:4];
                dmem.wdata = wdata_hi;
                if (dmem.ack) begin
                    hi_d    = dmem.rdata;
                    state_d = RESP;
                end else if (wait_q == WAIT_LAST) begin
                    // The first half of a split store stays written.
                    timeout_d = 1'b1;
                    state_d   = RESP;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end

            RESP: begin
                done    = 1'b1;
                err     = timeout_q;
                rdata   = (timeout_q | write_q) ? 32'h0 : load_data;
                rdata_d = rdata;
                err_d   = err;
                // The pipeline advances at the end of this cycle, so the
                // inputs seen here are the completing instruction's.
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    // Control state and the held response registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // flop samples the pre-edge value of its _d regardless of order.
        if (reset) begin
            state_q   <= IDLE;
            wait_q    <= 8'd0;
            timeout_q <= 1'b0;
            rdata_q   <= 32'h0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

    // NOTE: the request latches carry no reset; they are always loaded in
    // IDLE before any ACC or RESP cycle reads them.
    always_ff @(posedge clk) begin
        write_q <= write_d;
        uns_q   <= uns_d;
        size_q  <= size_d;
        off_q   <= off_d;
        waddr_q <= waddr_d;
        wdata_q <= wdata_d;
        lo_q    <= lo_d;
        hi_q    <= hi_d;
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// ----------------------------------------------------------------------------
// tb_lsu_ctrl
//   Scoreboard bench for lsu_ctrl. Each issued access is expanded by a
//   byte-level reference model into expected memory phases and an expected
//   response. A memory-slave process checks every phase the DUT presents and
//   acks it after the planned delay; a monitor checks every done pulse.
// ----------------------------------------------------------------------------
module tb_lsu_ctrl;
    import lsu_pkg::*;

    localparam int MAX_WAIT = 16;
    localparam int NO_ACK   = 255;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        int          delay;
    } phase_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  xfer_size = 3'd4;
    logic        is_unsigned = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        stall, done, err;
    logic [31:0] rdata;
    logic        slave_ack = 1'b0;
    logic        stray_ack = 1'b0;

    lsu_ctrl_if dmem_bus ();
    assign dmem_bus.ack = slave_ack | stray_ack;

    lsu_ctrl #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .xfer_size  (xfer_size),
        .is_unsigned(is_unsigned),
        .addr       (addr),
        .wdata      (wdata),
        .stall      (stall),
        .done       (done),
        .rdata      (rdata),
        .err        (err),
        .dmem       (dmem_bus)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    phase_t      phase_q[$];
    resp_t       resp_q[$];
    logic [31:0] ref_mem [logic [29:0]];
    logic [31:0] dut_mem [logic [29:0]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_note(input string name, input logic [31:0] act);
        vectors++;
        miscompares++;
        $display("FAIL %s: got %h, want nothing (t=%0t)", name, act, $time);
    endtask

    // ---------------- memory contents ----------------
    function automatic logic [31:0] init_word(input logic [29:0] wa);
        return {wa[15:0], ~wa[15:0]} ^ 32'h5A3C_96E1;
    endfunction

    function automatic logic [7:0] ref_rd_byte(input logic [31:0] ba);
        logic [31:0] w;
        w = ref_mem.exists(ba[31:2]) ? ref_mem[ba[31:2]] : init_word(ba[31:2]);
        return w[{ba[1:0], 3'b000} +: 8];
    endfunction

    task automatic ref_wr_byte(input logic [31:0] ba, input logic [7:0] b);
        logic [31:0] w;
        w = ref_mem.exists(ba[31:2]) ? ref_mem[ba[31:2]] : init_word(ba[31:2]);
        w[{ba[1:0], 3'b000} +: 8] = b;
        ref_mem[ba[31:2]] = w;
    endtask

    function automatic logic [31:0] dut_rd(input logic [29:0] wa);
        return dut_mem.exists(wa) ? dut_mem[wa] : init_word(wa);
    endfunction

    task automatic dut_wr(input logic [29:0] wa, input logic [31:0] d, input logic [3:0] be);
        logic [31:0] w;
        w = dut_rd(wa);
        for (int i = 0; i < 4; i++)
            if (be[i]) w[8*i +: 8] = d[8*i +: 8];
        dut_mem[wa] = w;
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] w);
        ref_mem[a[31:2]] = w;
        dut_mem[a[31:2]] = w;
    endtask

    // ---------------- reference model ----------------
    // Walks the access byte by byte: each byte belongs to the word holding
    // its address. Pushes the expected phases and (optionally) the response,
    // updates the reference memory, and returns the expected cycles to done.
    task automatic plan(input bit wr, input int sz, input bit uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int d0, input int d1, input bit want_resp,
                        output int lat);
        phase_t      p[2];
        logic [31:0] ba, val;
        int          k;
        bit          two, ok0, ok1, timed_out;
        resp_t       r;

        for (int j = 0; j < 2; j++) begin
            p[j].addr  = {a[31:2], 2'b00} + 32'(4 * j);
            p[j].be    = 4'h0;
            p[j].we    = wr;
            p[j].wdata = 32'h0;
        end
        p[0].delay = d0;
        p[1].delay = d1;

        for (int i = 0; i < sz; i++) begin
            ba = a + 32'(i);
            k  = (ba[31:2] == a[31:2]) ? 0 : 1;
            p[k].be[ba[1:0]] = 1'b1;
            p[k].wdata[{ba[1:0], 3'b000} +: 8] = wd[8*i +: 8];
        end
        two = (p[1].be != 4'h0);

        ok0 = (d0 < MAX_WAIT);
        ok1 = ok0 && (!two || d1 < MAX_WAIT);
        timed_out = !ok1;

        phase_q.push_back(p[0]);
        if (two && ok0) phase_q.push_back(p[1]);

        if (!ok0)          lat = 1 + MAX_WAIT;
        else if (!two)     lat = 2 + d0;
        else if (!ok1)     lat = 2 + d0 + MAX_WAIT;
        else               lat = 3 + d0 + d1;

        val = 32'h0;
        for (int i = 0; i < sz; i++) begin
            ba = a + 32'(i);
            k  = (ba[31:2] == a[31:2]) ? 0 : 1;
            if (wr) begin
                if ((k == 0 && ok0) || (k == 1 && ok0 && d1 < MAX_WAIT))
                    ref_wr_byte(ba, wd[8*i +: 8]);
            end else begin
                val[8*i +: 8] = ref_rd_byte(ba);
            end
        end
        if (!uns && sz < 4 && val[8*sz-1])
            for (int j = sz; j < 4; j++) val[8*j +: 8] = 8'hFF;

        r.err   = timed_out;
        r.rdata = (timed_out || wr) ? 32'h0 : val;
        if (want_resp) resp_q.push_back(r);
    endtask

    // ---------------- memory slave ----------------
    initial begin : slave
        int     wait_left;
        bit     in_phase;
        phase_t p;
        logic [31:0] m;
        wait_left = 0;
        in_phase  = 1'b0;
        dmem_bus.rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (slave_ack) in_phase = 1'b0;  // previous phase completed
            slave_ack = 1'b0;
            if (reset || !dmem_bus.req) begin
                in_phase = 1'b0;
            end else begin
                if (!in_phase) begin
                    in_phase = 1'b1;
                    if (phase_q.size() == 0) begin
                        fail_note("unexpected_req", dmem_bus.addr);
                        wait_left = NO_ACK;
                    end else begin
                        p = phase_q.pop_front();
                        check("ph_addr", dmem_bus.addr, p.addr);
                        check("ph_be", 32'(dmem_bus.be), 32'(p.be));
                        check("ph_we", 32'(dmem_bus.we), 32'(p.we));
                        if (p.we) begin
                            for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{p.be[i]}};
                            check("ph_wdata", dmem_bus.wdata & m, p.wdata);
                        end
                        wait_left = p.delay;
                    end
                end else if (wait_left > 0) begin
                    wait_left--;
                end
                if (wait_left == 0) begin
                    slave_ack      = 1'b1;
                    dmem_bus.rdata = dut_rd(dmem_bus.addr[31:2]);
                    if (dmem_bus.we) dut_wr(dmem_bus.addr[31:2], dmem_bus.wdata, dmem_bus.be);
                end
            end
        end
    end

    // ---------------- response monitor ----------------
    initial begin : monitor
        resp_t r;
        forever begin
            @(negedge clk);
            if (done) begin
                if (resp_q.size() == 0) begin
                    fail_note("unexpected_done", rdata);
                end else begin
                    r = resp_q.pop_front();
                    check("rdata", rdata, r.rdata);
                    check("err", 32'(err), 32'(r.err));
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic run_access(input bit rd, input bit wr, input logic [2:0] xs, input bit uns,
                              input logic [31:0] a, input logic [31:0] wd,
                              input int d0, input int d1);
        int sz, lat, n;
        bit got;
        sz = (xs == 3'd1) ? 1 : (xs == 3'd2) ? 2 : 4;
        @(negedge clk);
        plan(wr, sz, uns, a, wd, d0, d1, 1'b1, lat);
        mem_read    = rd;
        mem_write   = wr;
        xfer_size   = xs;
        is_unsigned = uns;
        addr        = a;
        wdata       = wd;
        #1 check("stall_req", 32'(stall), 32'd1);
        n   = 0;
        got = 1'b0;
        while (!got && n < lat + 4) begin
            @(negedge clk);
            n++;
            if (done) got = 1'b1;
            else      check("stall_busy", 32'(stall), 32'd1);
        end
        if (!got) begin
            fail_note("done_timeout", 32'(n));
        end else begin
            check("latency", 32'(n), 32'(lat));
            check("stall_resp", 32'(stall), 32'd0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            mem_read  = 1'b0;
            mem_write = 1'b0;
            #1 check("stall_idle", 32'(stall), 32'd0);
        end
    endtask

    function automatic int pick_delay();
        int s;
        s = int'($urandom_range(0, 19));
        if (s < 14)      return int'($urandom_range(0, 3));
        else if (s < 18) return 0;
        else if (s < 19) return MAX_WAIT - 1;
        else             return NO_ACK;
    endfunction

    // ---------------- main sequence ----------------
    initial begin : main
        int lat;
        bit rd, wr;
        logic [2:0] xs;
        logic [31:0] a;
        int sel;

        repeat (3) @(negedge clk);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_req", 32'(dmem_bus.req), 32'd0);
        check("rst_we", 32'(dmem_bus.we), 32'd0);
        check("rst_be", 32'(dmem_bus.be), 32'd0);
        check("rst_addr", dmem_bus.addr, 32'h0);
        check("rst_wdata", dmem_bus.wdata, 32'h0);
        reset = 1'b0;

        // Aligned word load, zero-wait memory.
        preload(32'h100, 32'h8000_00F0);
        run_access(1'b1, 1'b0, SZ_W, 1'b0, 32'h100, 32'h0, 0, 0);
        // Byte loads from the top lane, signed then unsigned.
        run_access(1'b1, 1'b0, SZ_B, 1'b0, 32'h103, 32'h0, 0, 0);
        run_access(1'b1, 1'b0, SZ_B, 1'b1, 32'h103, 32'h0, 0, 0);
        // Word-crossing halfword store.
        run_access(1'b0, 1'b1, SZ_H, 1'b0, 32'h203, 32'h0000_BEEF, 0, 0);
        run_access(1'b1, 1'b0, SZ_H, 1'b1, 32'h203, 32'h0, 1, 2);
        // Word-crossing word load with 3 wait cycles per phase.
        preload(32'h300, 32'h4433_1122);
        preload(32'h304, 32'h7788_6655);
        run_access(1'b1, 1'b0, SZ_W, 1'b0, 32'h302, 32'h0, 3, 3);
        // Timeouts: in the first phase, then in the second phase of a store.
        run_access(1'b1, 1'b0, SZ_W, 1'b0, 32'h400, 32'h0, NO_ACK, 0);
        run_access(1'b0, 1'b1, SZ_W, 1'b0, 32'h406, 32'hA1B2_C3D4, 1, NO_ACK);
        run_access(1'b1, 1'b0, SZ_W, 1'b0, 32'h404, 32'h0, 0, 0);
        // Longest wait that still completes.
        run_access(1'b1, 1'b0, SZ_H, 1'b0, 32'h10, 32'h0, MAX_WAIT - 1, 0);
        // Second phase wraps to word 0; both read and write means write.
        run_access(1'b1, 1'b0, SZ_W, 1'b0, 32'hFFFF_FFFE, 32'h0, 0, 0);
        run_access(1'b1, 1'b1, 3'd7, 1'b0, 32'h500, 32'hCAFE_F00D, 0, 0);
        run_access(1'b1, 1'b0, 3'd0, 1'b0, 32'h500, 32'h0, 0, 0);

        // Reset while the second phase is outstanding.
        @(negedge clk);
        plan(1'b0, 4, 1'b0, 32'h302, 32'h0, 0, NO_ACK, 1'b0, lat);
        mem_read = 1'b1; mem_write = 1'b0; xfer_size = SZ_W; is_unsigned = 1'b0; addr = 32'h302;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("acc1_req", 32'(dmem_bus.req), 32'd1);
        check("acc1_addr", dmem_bus.addr, 32'h304);
        reset    = 1'b1;
        mem_read = 1'b0;
        @(negedge clk);
        #1;
        check("post_rst_req", 32'(dmem_bus.req), 32'd0);
        check("post_rst_stall", 32'(stall), 32'd0);
        check("post_rst_done", 32'(done), 32'd0);
        reset     = 1'b0;
        stray_ack = 1'b1;
        @(negedge clk);
        #1;
        check("stray_ack_req", 32'(dmem_bus.req), 32'd0);
        check("stray_ack_done", 32'(done), 32'd0);
        stray_ack = 1'b0;
        run_access(1'b0, 1'b1, SZ_W, 1'b0, 32'h600, 32'h1357_9BDF, 0, 0);
        run_access(1'b1, 1'b0, SZ_W, 1'b0, 32'h600, 32'h0, 0, 0);

        // Randomised traffic over a small window plus the wrap region.
        for (int t = 0; t < 300; t++) begin
            sel = int'($urandom_range(0, 9));
            rd  = (sel < 5) || (sel == 9);
            wr  = (sel >= 5);
            case ($urandom_range(0, 7))
                0, 1:    xs = SZ_B;
                2, 3:    xs = SZ_H;
                4, 5:    xs = SZ_W;
                6:       xs = 3'd0;
                default: xs = 3'd7;
            endcase
            if ($urandom_range(0, 15) == 0) a = 32'hFFFF_FFF8 + $urandom_range(0, 7);
            else                            a = 32'h1000 + $urandom_range(0, 31);
            run_access(rd, wr, xs, 1'($urandom_range(0, 1)), a, $urandom, pick_delay(), pick_delay());
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
        end

        idle(4);
        check("phases_left", 32'(phase_q.size()), 32'd0);
        check("resps_left", 32'(resp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store sequencer in the MEM stage of the pipelined RV32I core.
- Takes the decoded memory controls (mem_read, mem_write, xfer_size, is_unsigned) plus the effective address and store data.
- Drives a word-addressed data-memory port with a req/ack handshake and stalls the pipeline while an access is in flight.
- Splits word-crossing (misaligned) accesses into two aligned transactions, then returns the sign- or zero-extended load result.

Parameters:
- MAX_WAIT, 16, cycles a phase waits for mem_ack before aborting with err (range 1..255).

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- mem_read  in  1  load request from MEM stage; held while stall=1
- mem_write  in  1  store request from MEM stage; held while stall=1
- xfer_size  in  3  bytes to transfer: 1, 2 or 4; any other value is treated as 4
- is_unsigned  in  1  zero-extend load result when 1
- addr  in  32  byte address
- wdata  in  32  store data, right-justified
- stall  out  1  freeze pipeline
- done  out  1  one-cycle completion pulse
- rdata  out  32  extended load result; valid when done=1
- err  out  1  timeout flag; valid when done=1
- dmem_req  out  1  memory request
- dmem_we  out  1  write enable
- dmem_addr  out  32  word-aligned address (bits [1:0]=0)
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-aligned write data
- dmem_ack  in  1  completes the phase when sampled with dmem_req=1
- dmem_rdata  in  32  read word; valid with dmem_ack

Behaviour:
- One clock domain: clk. Reset is synchronous, active-high.
- Reset values: state=IDLE; stall, done, err, dmem_req, dmem_we = 0; dmem_be = 0; rdata, dmem_addr, dmem_wdata = 0.
- Per-request latches: off = addr[1:0], mask = {1,3,F}[size], lanes = mask << off (8 bits), split = |lanes[7:4].
- States: IDLE, ACC0, ACC1, RESP.
- IDLE:
  - If mem_write or mem_read: latch the request; next state is ACC0. If both are asserted, it is a write.
  - stall = request (combinational), so the pipeline freezes in the request cycle.
  - Any dmem_ack in IDLE is ignored.
- ACC0:
  - dmem_req=1, dmem_addr={addr[31:2],2'b00}, dmem_be=lanes[3:0].
  - dmem_wdata=(wdata<<8*off)[31:0]; dmem_we=write.
  - All memory outputs are held stable until ack.
  - On ack: capture dmem_rdata into lo; next state is ACC1 if split, else RESP.
- ACC1:
  - dmem_addr = word address + 4 (wraps modulo 2^32), dmem_be=lanes[7:4], dmem_wdata=(wdata<<8*off)[63:32].
  - On ack: capture dmem_rdata into hi; next state is RESP.
- RESP:
  - done=1 and stall=0, so the pipeline advances at the end of this cycle.
  - rdata = extend(({hi,lo}>>8*off)[8*size-1:0]): sign-extended unless is_unsigned; word loads pass through.
  - Stores: rdata=0.
  - Next state is IDLE unconditionally. Inputs in RESP still belong to the completing instruction and are never re-accepted.
- stall = 1 in ACC0 and ACC1.
- Wait counter:
  - Clears on entry to each ACC phase and increments on each cycle without ack.
  - When it reaches MAX_WAIT without ack: go to RESP with err=1 and rdata=0; drop dmem_req; skip ACC1.
  - A partially written split store is not rolled back.
- Ack in the same cycle dmem_req rises is legal (zero-wait memory).
- Latency with zero-wait memory: aligned access gives request cycle 0, ACC0 in cycle 1, done in cycle 2 (stall high in cycles 0–1). A split access adds one cycle.
- Reset asserted in any state returns to IDLE on the next edge and clears dmem_req immediately after that edge; no done pulse is produced.
- err and rdata update only in RESP and hold their values until the next RESP.

Decomposition:
- lsu_pkg holds:
  - typedef enum for the states
  - constants SZ_B=1, SZ_H=2, SZ_W=4
  - function size_mask(size)
- Sub-module lsu_align (combinational): store lane shift, 8-bit lane-mask generation, and load extract/extend from {hi,lo}, off, size, is_unsigned.
- The FSM and wait counter stay in lsu_ctrl.

Test Plan:
- lw addr=0x100, mem word 0x8000_00F0, ack same cycle → dmem_addr=0x100, be=F; done in cycle 2; rdata=0x8000_00F0; stall high in cycles 0–1 only.
- lb addr=0x103, word 0x80xx_xxxx, is_unsigned=0 → rdata=0xFFFF_FF80; with is_unsigned=1 → rdata=0x0000_0080.
- sh addr=0x203, wdata=0xBEEF → phase 1: addr=0x200, be=8, wdata[31:24]=0xEF. Phase 2: addr=0x204, be=1, wdata[7:0]=0xBE. done after the second ack.
- lw addr=0x302 with ack after 3 wait cycles per phase, words 0x4433_xxxx and 0xxxxx_6655 → rdata=0x6655_4433; done exactly once.
- No ack, MAX_WAIT=16 → err=1, rdata=0, done after 16 ACC0 cycles; dmem_req low in RESP.
- reset asserted in ACC1 → IDLE next cycle, dmem_req=0, no done; a following ack is ignored; a new sw then completes normally.
